// File: rtl/key_responder.sv
// Key responder: buffers 4-bit keys in a small FIFO, counts occurrences per key after a
// fixed processing latency, and presents {key, count} on a valid/ready response port.
module key_responder #(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [3:0]       req_key,
    output logic             ack,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [3:0]       resp_key,
    output logic [CNT_W-1:0] resp_count,
    output logic             seq_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [3:0]       workKey_q, workKey_d;
    logic             respValid_q, respValid_d;
    logic [3:0]       respKey_q, respKey_d;
    logic [CNT_W-1:0] respCount_q, respCount_d;
    logic             tableWe;
    logic [CNT_W-1:0] bumped;

    logic [3:0]       fifoMem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, rdPtr_q;
    logic [CW-1:0]    count_q;
    logic             push, pop;

    logic [CNT_W-1:0] table_q [16];

    logic             baseSeen_q;
    logic [3:0]       lastKey_q;
    logic             seqErr_q;

    // ack depends only on the registered occupancy, so a same-cycle pop never frees a slot
    assign ack  = (count_q != CW'(DEPTH));
    assign push = req && ack;
    assign pop  = (state_q == IDLE) && (count_q != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= req_key;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // The first accepted key only establishes the baseline for the consecutive check
    always_ff @(posedge clk) begin
        if (rst) begin
            baseSeen_q <= 1'b0;
            lastKey_q  <= '0;
            seqErr_q   <= 1'b0;
        end else if (push) begin
            baseSeen_q <= 1'b1;
            lastKey_q  <= req_key;
            if (baseSeen_q && (req_key != lastKey_q + 4'd1)) begin
                seqErr_q <= 1'b1;
            end
        end
    end

    assign bumped = (table_q[workKey_q] == CNT_MAX) ? CNT_MAX : table_q[workKey_q] + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                table_q[i] <= '0;
            end
        end else if (tableWe) begin
            table_q[workKey_q] <= bumped;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        workKey_d   = workKey_q;
        respValid_d = respValid_q;
        respKey_d   = respKey_q;
        respCount_d = respCount_q;
        tableWe     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    workKey_d = fifoMem_q[rdPtr_q];
                    timer_d   = TW'(LATENCY - 1);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (timer_q == '0) begin
                    tableWe     = 1'b1;
                    respCount_d = bumped;
                    respKey_d   = workKey_q;
                    respValid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            RESP: begin
                // Return to IDLE without popping so the next key starts a fresh cycle
                if (resp_ready) begin
                    respValid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            workKey_q   <= '0;
            respValid_q <= 1'b0;
            respKey_q   <= '0;
            respCount_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            workKey_q   <= workKey_d;
            respValid_q <= respValid_d;
            respKey_q   <= respKey_d;
            respCount_q <= respCount_d;
        end
    end

    assign resp_valid = respValid_q;
    assign resp_key   = respKey_q;
    assign resp_count = respCount_q;
    assign seq_err    = seqErr_q;

endmodule

// File: tb/tb_key_responder.sv
// Bench for key_responder: directed vectors plus randomized traffic against a queue-based
// reference model; a second instance with 2-bit counters exercises saturation.
module tb_key_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic       resp_ready;
    logic [3:0] tbKey;
    logic [3:0] req_key;
    logic [3:0] upCnt;
    logic       upMode;

    logic       ack, resp_valid, seq_err;
    logic [3:0] resp_key;
    logic [7:0] resp_count;

    logic       satAck, satValid, satErr;
    logic [3:0] satKey;
    logic [1:0] satCount;

    always #5 clk = ~clk;

    // Upstream counter stage model: key is driven combinationally from ack
    assign req_key = upMode ? 4'(upCnt + {3'b000, ack}) : tbKey;

    key_responder #(.DEPTH(4), .LATENCY(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_key(req_key), .ack(ack),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_key(resp_key),
        .resp_count(resp_count), .seq_err(seq_err)
    );

    key_responder #(.DEPTH(4), .LATENCY(2), .CNT_W(2)) dutSat (
        .clk(clk), .rst(rst), .req(req), .req_key(req_key), .ack(satAck),
        .resp_valid(satValid), .resp_ready(resp_ready), .resp_key(satKey),
        .resp_count(satCount), .seq_err(satErr)
    );

    typedef struct {
        logic [3:0] key;
        int         c8;
        int         c2;
    } exp_t;

    typedef struct {
        bit         doReset;
        logic [3:0] key;
        logic [3:0] expKey;
        int         expC8;
        int         expC2;
        bit         expErr;
    } vec_t;

    exp_t       expQ[$];
    int         occ[16];
    bit         baseSeen;
    int         lastKey;
    bit         expErr;
    bit         stallPrev;
    int         stallKey;
    int         stallCount;
    bit         lastAcc;
    int         checks = 0;
    int         errors = 0;
    vec_t       vecs[12];

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference model, evaluated between edges on the values that the next edge will see
    task automatic checkOutput();
        exp_t e;
        int   k;
        if (rst) begin
            expQ.delete();
            for (int i = 0; i < 16; i++) occ[i] = 0;
            baseSeen  = 0;
            lastKey   = 0;
            expErr    = 0;
            stallPrev = 0;
            return;
        end
        check("seq_err", int'(seq_err), int'(expErr));
        check("sat_seq_err", int'(satErr), int'(expErr));
        if (stallPrev) begin
            check("stall_valid", int'(resp_valid), 1);
            check("stall_key", int'(resp_key), stallKey);
            check("stall_count", int'(resp_count), stallCount);
        end
        if (resp_valid && resp_ready) begin
            if (expQ.size() == 0) begin
                timeoutFail("unexpected_response");
            end else begin
                e = expQ.pop_front();
                check("resp_key", int'(resp_key), int'(e.key));
                check("resp_count", int'(resp_count), e.c8);
                check("sat_valid", int'(satValid), 1);
                check("sat_key", int'(satKey), int'(e.key));
                check("sat_count", int'(satCount), e.c2);
            end
        end
        stallPrev  = resp_valid && !resp_ready;
        stallKey   = int'(resp_key);
        stallCount = int'(resp_count);
        if (req && ack) begin
            k = int'(req_key);
            if (baseSeen && k != ((lastKey + 1) % 16)) expErr = 1;
            baseSeen = 1;
            lastKey  = k;
            occ[k]++;
            e.key = req_key;
            e.c8  = (occ[k] > 255) ? 255 : occ[k];
            e.c2  = (occ[k] > 3) ? 3 : occ[k];
            expQ.push_back(e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        checkOutput();
        lastAcc = req && ack && !rst;
        @(posedge clk);
        #1;
        if (upMode && lastAcc) upCnt = upCnt + 4'd1;
    endtask

    task automatic applyReset();
        rst        = 1'b1;
        req        = 1'b0;
        resp_ready = 1'b0;
        upMode     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", int'(resp_valid), 0);
        check("rst_ack", int'(ack), 1);
        check("rst_seq_err", int'(seq_err), 0);
        check("rst_key", int'(resp_key), 0);
        check("rst_count", int'(resp_count), 0);
    endtask

    task automatic applyStimulus(input logic [3:0] key);
        bit done;
        done  = 0;
        tbKey = key;
        req   = 1'b1;
        for (int n = 0; n < 64; n++) begin
            if (ack) begin
                tick();
                done = 1;
                break;
            end
            tick();
        end
        req = 1'b0;
        if (!done) timeoutFail("send_key");
    endtask

    task automatic waitResp(input logic [3:0] key, input int c8, input int c2, input bit err);
        bit found;
        found      = 0;
        resp_ready = 1'b1;
        for (int n = 0; n < 64; n++) begin
            if (resp_valid) begin
                found = 1;
                break;
            end
            tick();
        end
        if (!found) begin
            timeoutFail("wait_resp");
        end else begin
            check("vec_key", int'(resp_key), int'(key));
            check("vec_count", int'(resp_count), c8);
            check("vec_sat_count", int'(satCount), c2);
            check("vec_seq_err", int'(seq_err), int'(err));
            tick();
        end
    endtask

    task automatic drain();
        req        = 1'b0;
        resp_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (expQ.size() == 0 && !resp_valid) break;
            tick();
        end
        check("drain_left", expQ.size(), 0);
    endtask

    initial begin
        bit         pat[8];
        logic [3:0] nextKey;
        int         nextUp;

        rst        = 1'b1;
        req        = 1'b0;
        resp_ready = 1'b0;
        tbKey      = 4'd0;
        upMode     = 1'b0;
        upCnt      = 4'd0;

        vecs[0]  = '{1'b1, 4'd14, 4'd14, 1, 1, 1'b0};
        vecs[1]  = '{1'b0, 4'd15, 4'd15, 1, 1, 1'b0};
        vecs[2]  = '{1'b0, 4'd0,  4'd0,  1, 1, 1'b0};
        vecs[3]  = '{1'b0, 4'd1,  4'd1,  1, 1, 1'b0};
        vecs[4]  = '{1'b0, 4'd3,  4'd3,  1, 1, 1'b1};
        vecs[5]  = '{1'b0, 4'd4,  4'd4,  1, 1, 1'b1};
        vecs[6]  = '{1'b0, 4'd5,  4'd5,  1, 1, 1'b1};
        vecs[7]  = '{1'b0, 4'd7,  4'd7,  1, 1, 1'b1};
        vecs[8]  = '{1'b0, 4'd7,  4'd7,  2, 2, 1'b1};
        vecs[9]  = '{1'b0, 4'd7,  4'd7,  3, 3, 1'b1};
        vecs[10] = '{1'b0, 4'd7,  4'd7,  4, 3, 1'b1};
        vecs[11] = '{1'b0, 4'd7,  4'd7,  5, 3, 1'b1};

        // Latency and response spacing with keys 1,2,3 on consecutive accepts
        applyReset();
        resp_ready = 1'b1;
        pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            if (i < 3) begin
                req   = 1'b1;
                tbKey = 4'(i + 1);
                check("lat_ack", int'(ack), 1);
            end else begin
                req = 1'b0;
            end
            tick();
            check("lat_valid", int'(resp_valid), int'(pat[i]));
        end
        check("lat_second_key", int'(resp_key), 2);
        drain();
        check("lat_seq_err", int'(seq_err), 0);

        // Backpressure: five accepts fill FIFO plus working register
        applyReset();
        resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req   = 1'b1;
            tbKey = 4'(5 + i);
            check("bp_ack_open", int'(ack), 1);
            tick();
        end
        check("bp_ack_full", int'(ack), 0);
        check("bp_sat_ack_full", int'(satAck), 0);
        tbKey = 4'd10;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_ack_held", int'(ack), 0);
        end
        check("bp_stall_valid", int'(resp_valid), 1);
        check("bp_stall_key", int'(resp_key), 5);
        check("bp_stall_count", int'(resp_count), 1);
        drain();

        // Table-driven sequence wrap, sequence error and saturation
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].doReset) applyReset();
            applyStimulus(vecs[i].key);
            waitResp(vecs[i].expKey, vecs[i].expC8, vecs[i].expC2, vecs[i].expErr);
        end
        drain();

        // Reset mid-operation with FIFO half full and the FSM in WAIT
        applyReset();
        resp_ready = 1'b0;
        req        = 1'b1;
        tbKey      = 4'd9;
        tick();
        tbKey = 4'd3;
        tick();
        tbKey = 4'd9;
        tick();
        req = 1'b0;
        check("mid_seq_err_set", int'(seq_err), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_valid", int'(resp_valid), 0);
        check("mid_ack", int'(ack), 1);
        check("mid_seq_err", int'(seq_err), 0);
        applyStimulus(4'd9);
        waitResp(4'd9, 1, 1, 1'b0);
        drain();

        // Upstream counter stage driving req_key from ack
        applyReset();
        upCnt      = 4'd0;
        upMode     = 1'b1;
        req        = 1'b1;
        resp_ready = 1'b1;
        nextUp     = 1;
        for (int i = 0; i < 80; i++) begin
            if (resp_valid) begin
                check("up_key", int'(resp_key), nextUp);
                nextUp = (nextUp + 1) % 16;
            end
            tick();
        end
        req    = 1'b0;
        upMode = 1'b0;
        drain();
        check("up_seq_err", int'(seq_err), 0);

        // Randomized traffic, mostly consecutive keys, with occasional resets
        applyReset();
        nextKey = 4'd0;
        for (int i = 0; i < 1500; i++) begin
            if (lastAcc) nextKey = tbKey + 4'd1;
            rst        = ($urandom_range(0, 299) == 0);
            req        = ($urandom_range(0, 2) != 0);
            resp_ready = ($urandom_range(0, 3) != 0);
            tbKey      = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : nextKey;
            tick();
        end
        rst = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
